// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer and its return-stack link.
package pc_sequencer_pkg;

  localparam int PC_WIDTH_DEFAULT    = 8;
  localparam int STACK_DEPTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_HALT = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERFLOW  = 2'd1,
    FC_UNDERFLOW = 2'd2,
    FC_ILLEGAL   = 2'd3
  } fault_e;

  // Depth must represent 0..STACK_DEPTH inclusive, hence the extra bit.
  function automatic int depth_bits(input int stack_depth);
    return $clog2(stack_depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction, status and return-stack link bundle between a controller and pc_sequencer.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
);

  logic                               instr_valid;
  logic [2:0]                         op;
  logic [PC_WIDTH-1:0]                target;
  logic                               stall;
  logic                               clear;
  logic [PC_WIDTH-1:0]                return_to;
  logic [PC_WIDTH-1:0]                pc;
  logic                               call;
  logic                               ret;
  logic                               stk_reset;
  logic [PC_WIDTH-1:0]                called_from;
  logic [depth_bits(STACK_DEPTH)-1:0] depth;
  logic [1:0]                         state;
  logic [1:0]                         fault_code;

  modport master (
    output instr_valid, op, target, stall, clear, return_to,
    input  pc, call, ret, stk_reset, called_from, depth, state, fault_code
  );

  modport slave (
    input  instr_valid, op, target, stall, clear, return_to,
    output pc, call, ret, stk_reset, called_from, depth, state, fault_code
  );

endinterface

// File: rtl/pc_sequencer_depth_counter.sv
// Saturating up/down counter tracking how many return addresses the external stack holds.
module depth_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  assign full  = (count == W'(MAX));
  assign empty = (count == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (up && !down && !full) begin
      count <= count + W'(1);
    end else if (down && !up && !empty) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: NEXT/JUMP/CALL/RET/HALT with overflow, underflow and illegal-op faults.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic           clock,
  input  logic           reset_n,
  pc_sequencer_if.slave  bus
);

  localparam int DW = depth_bits(STACK_DEPTH);

  localparam logic [1:0] RUN    = ST_RUN;
  localparam logic [1:0] HALTED = ST_HALTED;
  localparam logic [1:0] FAULT  = ST_FAULT;

  logic [PC_WIDTH-1:0] pc_q;
  logic [1:0]          state_q;
  logic [1:0]          fault_q;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;
  logic                active;
  logic                push;
  logic                pop;

  // An instruction is only acted on in RUN when neither clear nor stall intervenes.
  assign active = (state_q == RUN) && bus.instr_valid && !bus.stall && !bus.clear;
  assign push   = active && (bus.op == OP_CALL) && !full;
  assign pop    = active && (bus.op == OP_RET)  && !empty;

  assign bus.call        = reset_n && push;
  assign bus.ret         = reset_n && pop;
  assign bus.stk_reset   = !reset_n || bus.clear;
  assign bus.pc          = pc_q;
  assign bus.called_from = pc_q;
  assign bus.depth       = depth;
  assign bus.state       = state_q;
  assign bus.fault_code  = fault_q;

  depth_counter #(
    .MAX (STACK_DEPTH),
    .W   (DW)
  ) u_depth (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.clear),
    .up      (push),
    .down    (pop),
    .count   (depth),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      state_q <= RUN;
      fault_q <= FC_NONE;
    end else if (bus.clear) begin
      pc_q    <= '0;
      state_q <= RUN;
      fault_q <= FC_NONE;
    end else if (active) begin
      case (bus.op)
        OP_NEXT: pc_q <= pc_q + PC_WIDTH'(1);
        OP_JUMP: pc_q <= bus.target;
        OP_CALL: begin
          if (full) begin
            state_q <= FAULT;
            fault_q <= FC_OVERFLOW;
          end else begin
            pc_q <= bus.target;
          end
        end
        OP_RET: begin
          if (empty) begin
            state_q <= FAULT;
            fault_q <= FC_UNDERFLOW;
          end else begin
            pc_q <= bus.return_to;
          end
        end
        OP_HALT: state_q <= HALTED;
        default: begin
          state_q <= FAULT;
          fault_q <= FC_ILLEGAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int PW   = 8;
  localparam int SD   = 16;
  localparam int MASK = (1 << PW) - 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus();

  pc_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: architectural pc/state/fault plus an array standing in for the return stack.
  int m_pc;
  int m_state;
  int m_fault;
  int m_depth;
  int m_stk [SD];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc    <= 0;
      m_state <= 0;
      m_fault <= 0;
      m_depth <= 0;
    end else if (bus.clear) begin
      m_pc    <= 0;
      m_state <= 0;
      m_fault <= 0;
      m_depth <= 0;
    end else if (!bus.stall && m_state == 0 && bus.instr_valid) begin
      case (int'(bus.op))
        0: m_pc <= (m_pc + 1) & MASK;
        1: m_pc <= int'(bus.target);
        2: begin
          if (m_depth < SD) begin
            m_stk[m_depth] <= (m_pc + 1) & MASK;
            m_depth        <= m_depth + 1;
            m_pc           <= int'(bus.target);
          end else begin
            m_state <= 2;
            m_fault <= 1;
          end
        end
        3: begin
          if (m_depth > 0) begin
            m_depth <= m_depth - 1;
            m_pc    <= int'(bus.return_to);
          end else begin
            m_state <= 2;
            m_fault <= 2;
          end
        end
        4: m_state <= 1;
        default: begin
          m_state <= 2;
          m_fault <= 3;
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel();
    bit en;
    en = reset_n && !bus.clear && !bus.stall && (m_state == 0) && bus.instr_valid;
    checkOutput("pc",          int'(bus.pc),          m_pc);
    checkOutput("called_from", int'(bus.called_from), m_pc);
    checkOutput("depth",       int'(bus.depth),       m_depth);
    checkOutput("state",       int'(bus.state),       m_state);
    checkOutput("fault_code",  int'(bus.fault_code),  m_fault);
    checkOutput("call",        int'(bus.call),        int'(en && bus.op == 3'd2 && m_depth < SD));
    checkOutput("ret",         int'(bus.ret),         int'(en && bus.op == 3'd3 && m_depth > 0));
    checkOutput("stk_reset",   int'(bus.stk_reset),   int'(!reset_n || bus.clear));
  endtask

  // Drive one cycle's inputs on the falling edge, then compare against the model before the next rise.
  task automatic applyStimulus(input bit v, input int o, input int t, input bit s, input bit c);
    @(negedge clock);
    bus.instr_valid = v;
    bus.op          = 3'(o);
    bus.target      = PW'(t);
    bus.stall       = s;
    bus.clear       = c;
    if (m_depth > 0 && $urandom_range(0, 9) != 0)
      bus.return_to = PW'(m_stk[m_depth-1]);
    else
      bus.return_to = PW'($urandom_range(0, MASK));
    #2;
    compareModel();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.op          = '0;
    bus.target      = '0;
    bus.stall       = 1'b0;
    bus.clear       = 1'b0;
    bus.return_to   = '0;

    idle();
    checkOutput("reset_stk_reset", int'(bus.stk_reset), 1);
    checkOutput("reset_pc", int'(bus.pc), 0);
    idle();
    reset_n = 1'b1;

    // Sequential stepping from reset
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkOutput("next_pc0", int'(bus.pc), 0);
    checkOutput("next_call0", int'(bus.call), 0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkOutput("next_pc1", int'(bus.pc), 1);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkOutput("next_pc2", int'(bus.pc), 2);
    checkOutput("next_ret2", int'(bus.ret), 0);
    idle();
    checkOutput("next_pc3", int'(bus.pc), 3);

    // Call from 5 to 0x40 and return to 6
    applyStimulus(1'b1, 1, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 8'h40, 1'b0, 1'b0);
    checkOutput("call_pulse", int'(bus.call), 1);
    checkOutput("call_from", int'(bus.called_from), 5);
    applyStimulus(1'b1, 3, 0, 1'b0, 1'b0);
    checkOutput("call_pc", int'(bus.pc), 8'h40);
    checkOutput("call_depth", int'(bus.depth), 1);
    checkOutput("model_top", m_stk[0], 6);
    checkOutput("ret_pulse", int'(bus.ret), 1);
    idle();
    checkOutput("ret_pc", int'(bus.pc), 6);
    checkOutput("ret_depth", int'(bus.depth), 0);

    // Overflow on the 17th nested call, recovered by clear
    for (int i = 0; i < SD; i++) applyStimulus(1'b1, 2, 8'h80 + i, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 8'h11, 1'b0, 1'b0);
    checkOutput("ovf_no_call", int'(bus.call), 0);
    checkOutput("ovf_depth16", int'(bus.depth), 16);
    idle();
    checkOutput("ovf_state", int'(bus.state), 2);
    checkOutput("ovf_code", int'(bus.fault_code), 1);
    checkOutput("ovf_pc_hold", int'(bus.pc), 8'h8F);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("clr_stk_reset", int'(bus.stk_reset), 1);
    idle();
    checkOutput("clr_pc", int'(bus.pc), 0);
    checkOutput("clr_depth", int'(bus.depth), 0);
    checkOutput("clr_state", int'(bus.state), 0);

    // Underflow, then instructions ignored while faulted
    applyStimulus(1'b1, 3, 0, 1'b0, 1'b0);
    checkOutput("udf_no_ret", int'(bus.ret), 0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkOutput("udf_state", int'(bus.state), 2);
    checkOutput("udf_code", int'(bus.fault_code), 2);
    idle();
    checkOutput("udf_pc_hold", int'(bus.pc), 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // Stall suppresses a call; clear beats a simultaneous call
    applyStimulus(1'b1, 1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2, 8'h20, 1'b1, 1'b0);
    checkOutput("stall_no_call", int'(bus.call), 0);
    applyStimulus(1'b1, 2, 8'h20, 1'b0, 1'b1);
    checkOutput("stall_pc", int'(bus.pc), 8'h10);
    checkOutput("clrcall_no_call", int'(bus.call), 0);
    idle();
    checkOutput("clrcall_pc", int'(bus.pc), 0);
    checkOutput("clrcall_depth", int'(bus.depth), 0);

    // Wrap at the top of the address space, then an asynchronous reset mid-cycle
    applyStimulus(1'b1, 1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    checkOutput("wrap_pc_ff", int'(bus.pc), 8'hFF);
    applyStimulus(1'b1, 2, 8'h33, 1'b0, 1'b0);
    checkOutput("wrap_pc_00", int'(bus.pc), 0);
    idle();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_pc", int'(bus.pc), 0);
    checkOutput("async_depth", int'(bus.depth), 0);
    checkOutput("async_stk_reset", int'(bus.stk_reset), 1);
    checkOutput("async_call", int'(bus.call), 0);
    idle();
    reset_n = 1'b1;

    // Randomized traffic; every other 300-cycle window favours calls to reach overflow
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      int o;
      bit heavy;
      heavy = ((cyc / 300) % 2) == 1;
      r = $urandom_range(0, 99);
      if (heavy)
        o = (r < 10) ? 0 : (r < 15) ? 1 : (r < 80) ? 2 : (r < 97) ? 3 : 4;
      else
        o = (r < 25) ? 0 : (r < 45) ? 1 : (r < 70) ? 2 : (r < 93) ? 3 : (r < 97) ? 4 : $urandom_range(5, 7);
      applyStimulus($urandom_range(0, 99) < 85, o, $urandom_range(0, MASK),
                    $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of program counter and call/return addresses.
REQ-002 Parameter STACK_DEPTH, default 16, number of return-stack entries tracked.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 instr_valid  in  1  an instruction is presented this cycle.
REQ-006 op  in  3  operation: NEXT=0, JUMP=1, CALL=2, RET=3, HALT=4; values 5-7 are illegal.
REQ-007 target  in  PC_WIDTH  jump/call destination.
REQ-008 stall  in  1  hold all state; no stack command issued.
REQ-009 clear  in  1  synchronous fault/halt clear.
REQ-010 return_to  in  PC_WIDTH  top-of-stack return address from the return stack, combinational.
REQ-011 pc  out  PC_WIDTH  current program counter.
REQ-012 call  out  1  push command to the return stack.
REQ-013 ret  out  1  pop command to the return stack.
REQ-014 stk_reset  out  1  return-stack pointer clear command.
REQ-015 called_from  out  PC_WIDTH  address of the calling instruction; equals pc.
REQ-016 depth  out  $clog2(STACK_DEPTH)+1  current number of stacked return addresses.
REQ-017 state  out  2  RUN=0, HALTED=1, FAULT=2.
REQ-018 fault_code  out  2  NONE=0, OVERFLOW=1, UNDERFLOW=2, ILLEGAL=3.

Function
REQ-019 call, ret and stk_reset SHALL be combinational, and at most one SHALL be high in any cycle.
REQ-020 In RUN, with instr_valid=1, stall=0 and clear=0, the block SHALL act on op in that cycle; the new pc is visible the next cycle.
REQ-021 NEXT SHALL set pc to pc+1, wrapping modulo 2^PC_WIDTH.
REQ-022 JUMP SHALL set pc to target.
REQ-023 CALL with depth<STACK_DEPTH SHALL assert call for one cycle, set pc to target, and increment depth; the stack stores called_from+1.
REQ-024 CALL with depth=STACK_DEPTH SHALL NOT assert call; the block enters FAULT with fault_code OVERFLOW, and pc holds.
REQ-025 RET with depth>0 SHALL assert ret for one cycle, set pc to return_to sampled in the same cycle, and decrement depth.
REQ-026 RET with depth=0 SHALL NOT assert ret; the block enters FAULT with fault_code UNDERFLOW, and pc holds.
REQ-027 HALT SHALL move the block to HALTED with pc unchanged.
REQ-028 An op value of 5-7 SHALL move the block to FAULT with fault_code ILLEGAL.
REQ-029 With instr_valid=0 in RUN, pc and depth SHALL hold.
REQ-030 stall=1 SHALL hold pc, depth and state and suppress call/ret; clear takes priority over stall.
REQ-031 In HALTED and FAULT, instructions SHALL be ignored and call/ret stay low.
REQ-032 clear=1 in any state SHALL, in that cycle, assert stk_reset; next cycle pc=0, depth=0, state=RUN, fault_code=NONE.
REQ-033 clear SHALL take priority over a simultaneous instruction.
REQ-034 fault_code SHALL hold until clear or reset.

Reset
REQ-035 reset_n=0 SHALL asynchronously force pc=0, depth=0, state=RUN and fault_code=NONE.
REQ-036 While reset_n=0, call and ret SHALL be 0 and stk_reset SHALL be 1.
REQ-037 Reset asserted mid-CALL or mid-RET SHALL abort the operation with no partial depth update.

Structure
REQ-038 A shared package SHALL hold the op, state and fault_code enums and the PC_WIDTH default.
REQ-039 One sub-module SHALL be used: depth_counter (saturating up/down counter with full and empty flags).
REQ-040 The return-stack storage SHALL remain an external block connected via call, ret, stk_reset, called_from and return_to.

Verification
REQ-041 Reset, then NEXT x3 -> pc 0,1,2,3 with call and ret never asserted.
REQ-042 At pc=5, CALL target=0x40 -> call=1 with called_from=5, pc=0x40, depth=1; then RET with return_to=6 -> ret=1, pc=6, depth=0.
REQ-043 16 nested CALLs, then a 17th CALL -> no call pulse, state=FAULT, fault_code=OVERFLOW, depth=16; then clear -> stk_reset=1, pc=0, depth=0, state=RUN.
REQ-044 RET at depth=0 -> ret=0, FAULT with fault_code UNDERFLOW; subsequent NEXT is ignored.
REQ-045 CALL with stall=1 -> no call, pc and depth unchanged; CALL together with clear -> clear wins, no call, pc=0.
REQ-046 With pc=0xFF, NEXT -> pc=0x00; reset_n pulsed low mid-cycle -> pc=0 immediately, stk_reset=1.
